// File: rtl/aes_pkg.sv
// AES shared definitions: S-boxes, round constants, byte/column
// helpers and the cipher core FSM encoding.
package aes_pkg;

   typedef enum logic [1:0] {IDLE, KEXP, RUN, HOLD} fsm_e;

   localparam logic [7:0] SBOX [256] = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16};

   localparam logic [7:0] ISBOX [256] = '{
      8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
      8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
      8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
      8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
      8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
      8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
      8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
      8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
      8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
      8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
      8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
      8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
      8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
      8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
      8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
      8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d};

   localparam logic [7:0] RCON [10] = '{
      8'h01,8'h02,8'h04,8'h08,8'h10,8'h20,8'h40,8'h80,8'h1b,8'h36};

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] k);
      logic [7:0] p, a;
      p = '0;
      a = b;
      for (int i = 0; i < 4; i++) begin
         if (k[i]) p = p ^ a;
         a = xtime(a);
      end
      return p;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = c;
      return {gmul(a0, 4'd2) ^ gmul(a1, 4'd3) ^ a2 ^ a3,
              a0 ^ gmul(a1, 4'd2) ^ gmul(a2, 4'd3) ^ a3,
              a0 ^ a1 ^ gmul(a2, 4'd2) ^ gmul(a3, 4'd3),
              gmul(a0, 4'd3) ^ a1 ^ a2 ^ gmul(a3, 4'd2)};
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = c;
      return {gmul(a0, 4'd14) ^ gmul(a1, 4'd11) ^ gmul(a2, 4'd13) ^ gmul(a3, 4'd9),
              gmul(a0, 4'd9) ^ gmul(a1, 4'd14) ^ gmul(a2, 4'd11) ^ gmul(a3, 4'd13),
              gmul(a0, 4'd13) ^ gmul(a1, 4'd9) ^ gmul(a2, 4'd14) ^ gmul(a3, 4'd11),
              gmul(a0, 4'd11) ^ gmul(a1, 4'd13) ^ gmul(a2, 4'd9) ^ gmul(a3, 4'd14)};
   endfunction

   // Byte n sits at column n/4, row n%4, byte 0 in the top bits.
   function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
      logic [127:0] t;
      t = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            t[127-8*(4*c+r) -: 8] = s[127-8*(4*((c + (inv ? 4 - r : r)) % 4)+r) -: 8];
      return t;
   endfunction

   function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
      logic [127:0] t;
      t = '0;
      for (int n = 0; n < 16; n++)
         t[127-8*n -: 8] = inv ? ISBOX[s[127-8*n -: 8]] : SBOX[s[127-8*n -: 8]];
      return t;
   endfunction

   function automatic logic [127:0] mix_cols(input logic [127:0] s, input logic inv);
      logic [127:0] t;
      t = '0;
      for (int c = 0; c < 4; c++)
         t[127-32*c -: 32] = inv ? inv_mix_col(s[127-32*c -: 32]) : mix_col(s[127-32*c -: 32]);
      return t;
   endfunction

endpackage

// File: rtl/aes_key_sched.sv
// AES key expansion: loads the cipher key, grows one schedule word per
// step and serves one 128-bit round key per round index.
module aes_key_sched
   import aes_pkg::*;
#(
   parameter int NK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             step_i,
   input  logic [NK*32-1:0] key_i,
   input  logic [3:0]       rd_idx_i,
   output logic [127:0]     rk_o,
   output logic             last_o
);
   localparam int NR = NK + 6;
   localparam int NW = 4 * (NR + 1);

   logic [31:0] w_q [NW];
   logic [5:0]  i_q, i_d;
   logic [2:0]  j_q, j_d;
   logic [3:0]  rc_q, rc_d;
   logic [31:0] prev, temp, nw;
   logic [5:0]  base;

   // j_q tracks i mod NK and rc_q tracks i/NK - 1 without dividers.
   always_comb begin
      prev = w_q[i_q - 6'd1];
      if (j_q == 3'd0)
         temp = sub_word(rot_word(prev)) ^ {RCON[rc_q], 24'h0};
      else if (NK == 8 && j_q == 3'd4)
         temp = sub_word(prev);
      else
         temp = prev;
      nw   = w_q[i_q - 6'(NK)] ^ temp;
      i_d  = i_q + 6'd1;
      j_d  = (j_q == 3'(NK - 1)) ? 3'd0 : j_q + 3'd1;
      rc_d = (j_q == 3'd0) ? rc_q + 4'd1 : rc_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         i_q  <= '0;
         j_q  <= '0;
         rc_q <= '0;
      end else if (load_i) begin
         i_q  <= 6'(NK);
         j_q  <= '0;
         rc_q <= '0;
      end else if (step_i) begin
         i_q  <= i_d;
         j_q  <= j_d;
         rc_q <= rc_d;
      end
   end

   always_ff @(posedge clk) begin
      if (load_i) begin
         for (int k = 0; k < NK; k++)
            w_q[k] <= key_i[NK*32-1-32*k -: 32];
      end else if (step_i) begin
         w_q[i_q] <= nw;
      end
   end

   assign base   = {rd_idx_i, 2'b00};
   assign rk_o   = {w_q[base], w_q[base + 6'd1], w_q[base + 6'd2], w_q[base + 6'd3]};
   assign last_o = (i_q == 6'(NW - 1));

endmodule

// File: rtl/aes_cipher_core.sv
// Iterative AES cipher core: runtime encrypt/decrypt, one round per
// cycle, with an in-core key expansion phase.
module aes_cipher_core
   import aes_pkg::*;
#(
   parameter int KEY_BITS = 256
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [KEY_BITS-1:0] key_in,
   input  logic                key_valid,
   output logic                key_ready,
   input  logic                mode,
   input  logic [127:0]        in_data,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [127:0]        out_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                key_loaded
);
   localparam int NK = KEY_BITS / 32;
   localparam int NR = NK + 6;
   localparam logic [3:0] LAST = 4'(NR);

   if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key
      $error("aes_cipher_core: KEY_BITS must be 128, 192 or 256");
   end

   fsm_e         fsm_q;
   logic [127:0] st_q, out_q, rk, rnd;
   logic [3:0]   r_q, rd_idx;
   logic         mode_q, kl_q, ov_q;
   logic         key_acc, blk_acc, ks_last, last_rnd;

   assign key_ready  = (fsm_q == IDLE);
   assign in_ready   = (fsm_q == IDLE) & kl_q & ~key_valid;
   assign key_acc    = key_valid & key_ready;
   assign blk_acc    = in_valid & in_ready;
   assign out_data   = out_q;
   assign out_valid  = ov_q;
   assign key_loaded = kl_q;
   assign last_rnd   = (r_q == LAST);

   // In IDLE the port serves the whitening key for the offered block.
   assign rd_idx = (fsm_q == IDLE) ? (mode ? LAST : 4'd0)
                                   : (mode_q ? LAST - r_q : r_q);

   aes_key_sched #(.NK(NK)) u_ks (
      .clk      (clk),
      .rst      (rst),
      .load_i   (key_acc),
      .step_i   (fsm_q == KEXP),
      .key_i    (key_in),
      .rd_idx_i (rd_idx),
      .rk_o     (rk),
      .last_o   (ks_last)
   );

   always_comb begin
      if (!mode_q) begin
         rnd = shift_rows(sub_bytes(st_q, 1'b0), 1'b0);
         if (!last_rnd) rnd = mix_cols(rnd, 1'b0);
         rnd = rnd ^ rk;
      end else begin
         rnd = sub_bytes(shift_rows(st_q, 1'b1), 1'b1) ^ rk;
         if (!last_rnd) rnd = mix_cols(rnd, 1'b1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fsm_q  <= IDLE;
         st_q   <= '0;
         out_q  <= '0;
         r_q    <= '0;
         mode_q <= 1'b0;
         kl_q   <= 1'b0;
         ov_q   <= 1'b0;
      end else begin
         unique case (fsm_q)
            IDLE: begin
               if (key_acc) begin
                  fsm_q <= KEXP;
                  kl_q  <= 1'b0;
               end else if (blk_acc) begin
                  fsm_q  <= RUN;
                  st_q   <= in_data ^ rk;
                  r_q    <= 4'd1;
                  mode_q <= mode;
               end
            end
            KEXP: begin
               if (ks_last) begin
                  fsm_q <= IDLE;
                  kl_q  <= 1'b1;
               end
            end
            RUN: begin
               if (last_rnd) begin
                  fsm_q <= HOLD;
                  out_q <= rnd;
                  ov_q  <= 1'b1;
               end else begin
                  st_q <= rnd;
                  r_q  <= r_q + 4'd1;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  fsm_q <= IDLE;
                  ov_q  <= 1'b0;
               end
            end
            default: fsm_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_cipher_core.sv
// Scoreboard bench for aes_cipher_core: three instances (128/192/256-bit
// keys) driven with FIPS-197 vectors plus handshake and reset scenarios.
module tb_aes_cipher_core;
   import aes_pkg::*;

   localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [255:0] K128  = 256'h000102030405060708090a0b0c0d0e0f;
   localparam logic [255:0] K192  = 256'h000102030405060708090a0b0c0d0e0f1011121314151617;
   localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

   typedef struct {
      int           g;
      logic [127:0] d;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic [255:0] key_in [3];
   logic         key_valid [3], key_ready [3], mode [3];
   logic         in_valid [3], in_ready [3];
   logic         out_valid [3], out_ready [3], key_loaded [3];
   logic [127:0] in_data [3], out_data [3];

   exp_t sb [$];
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int KB = 128 + 64 * g;
      aes_cipher_core #(.KEY_BITS(KB)) u_dut (
         .clk        (clk),
         .rst        (rst),
         .key_in     (key_in[g][KB-1:0]),
         .key_valid  (key_valid[g]),
         .key_ready  (key_ready[g]),
         .mode       (mode[g]),
         .in_data    (in_data[g]),
         .in_valid   (in_valid[g]),
         .in_ready   (in_ready[g]),
         .out_data   (out_data[g]),
         .out_valid  (out_valid[g]),
         .out_ready  (out_ready[g]),
         .key_loaded (key_loaded[g])
      );
   end

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: every accepted result is matched against the queue head.
   always @(negedge clk) begin : mon
      exp_t e;
      for (int g = 0; g < 3; g++) begin
         if (rst && out_valid[g] && out_ready[g]) begin
            if (sb.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_out inst %0d: got %h expected none", g, out_data[g]);
            end else begin
               e = sb.pop_front();
               chk($sformatf("sb_inst%0d", g), 128'(g), 128'(e.g));
               chk($sformatf("sb_data%0d", g), out_data[g], e.d);
            end
         end
      end
   end

   task automatic load_key(input int g, input logic [255:0] k, input logic with_in);
      int n;
      key_in[g]    = k;
      key_valid[g] = 1'b1;
      if (with_in) begin
         in_valid[g] = 1'b1;
         in_data[g]  = PT;
         mode[g]     = 1'b0;
      end
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!key_ready[g] && n < 200);
      if (with_in) chk("prio_in_ready", 128'(in_ready[g]), 128'(0));
      chk("key_ready", 128'(key_ready[g]), 128'(1));
      @(posedge clk);
      #1;
      key_valid[g] = 1'b0;
      in_valid[g]  = 1'b0;
      chk("kexp_loaded_low", 128'(key_loaded[g]), 128'(0));
      n = 0;
      do begin
         @(posedge clk);
         n++;
         #1;
      end while (!key_loaded[g] && n < 200);
      chk($sformatf("kexp_cycles%0d", g), 128'(n), 128'(4 * (11 + 2 * g) - (4 + 2 * g)));
   endtask

   task automatic issue(input int g, input logic md, input logic [127:0] d,
                        input logic [127:0] exp, input logic push, output int waited);
      exp_t e;
      if (push) begin
         e.g = g;
         e.d = exp;
         sb.push_back(e);
      end
      mode[g]     = md;
      in_data[g]  = d;
      in_valid[g] = 1'b1;
      waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (!in_ready[g] && waited < 200);
      chk("blk_accept", 128'(in_ready[g]), 128'(1));
      @(posedge clk);
      #1;
      in_valid[g] = 1'b0;
   endtask

   task automatic wait_out(input int g, input string nm);
      int   n;
      logic busy_rdy;
      n = 0;
      busy_rdy = 1'b0;
      do begin
         @(posedge clk);
         n++;
         #1;
         if (!out_valid[g]) busy_rdy = busy_rdy | in_ready[g] | key_ready[g];
      end while (!out_valid[g] && n < 40);
      chk({nm, "_lat"}, 128'(n), 128'(10 + 2 * g));
      chk({nm, "_busy_rdy"}, 128'(busy_rdy), 128'(0));
   endtask

   task automatic release_out(input int g, input int hold, input logic [127:0] exp);
      logic stable;
      stable = 1'b1;
      repeat (hold) begin
         @(negedge clk);
         if (!(out_valid[g] === 1'b1 && out_data[g] === exp && in_ready[g] === 1'b0))
            stable = 1'b0;
      end
      if (hold > 0) chk("hold_stable", 128'(stable), 128'(1));
      out_ready[g] = 1'b1;
      @(posedge clk);
      #1;
      out_ready[g] = 1'b0;
      chk("out_valid_drop", 128'(out_valid[g]), 128'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int   w;
      logic seen;
      rst = 1'b0;
      for (int g = 0; g < 3; g++) begin
         key_in[g]    = '0;
         key_valid[g] = 1'b0;
         mode[g]      = 1'b0;
         in_data[g]   = '0;
         in_valid[g]  = 1'b0;
         out_ready[g] = 1'b0;
      end
      repeat (3) @(negedge clk);
      chk("rst_out_valid", 128'(out_valid[2]), 128'(0));
      chk("rst_key_loaded", 128'(key_loaded[2]), 128'(0));
      chk("rst_out_data", out_data[2], 128'(0));
      chk("rst_key_ready", 128'(key_ready[2]), 128'(1));
      chk("rst_in_ready", 128'(in_ready[2]), 128'(0));
      rst = 1'b1;

      in_valid[2] = 1'b1;
      in_data[2]  = PT;
      seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         seen = seen | in_ready[2];
      end
      chk("nokey_in_ready", 128'(seen), 128'(0));
      in_valid[2] = 1'b0;

      load_key(2, K256, 1'b0);

      // Backpressure with a second block already offered.
      issue(2, 1'b0, PT, CT256, 1'b1, w);
      mode[2]     = 1'b1;
      in_data[2]  = CT256;
      in_valid[2] = 1'b1;
      wait_out(2, "enc256");
      release_out(2, 5, CT256);
      issue(2, 1'b1, CT256, PT, 1'b1, w);
      chk("second_wait", 128'(w), 128'(1));
      wait_out(2, "dec256");
      release_out(2, 0, PT);

      load_key(2, K256, 1'b1);

      issue(2, 1'b1, CT256, PT, 1'b1, w);
      key_in[2]    = '1;
      key_valid[2] = 1'b1;
      wait_out(2, "dec_keyv");
      key_valid[2] = 1'b0;
      release_out(2, 0, PT);
      chk("keyv_loaded", 128'(key_loaded[2]), 128'(1));
      issue(2, 1'b0, PT, CT256, 1'b1, w);
      wait_out(2, "enc_after_keyv");
      release_out(2, 0, CT256);

      // Abort in round 7.
      issue(2, 1'b0, PT, CT256, 1'b0, w);
      repeat (6) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("abort_out_valid", 128'(out_valid[2]), 128'(0));
      chk("abort_key_loaded", 128'(key_loaded[2]), 128'(0));
      chk("abort_out_data", out_data[2], 128'(0));
      chk("abort_key_ready", 128'(key_ready[2]), 128'(1));
      repeat (2) @(negedge clk);
      rst = 1'b1;
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         seen = seen | out_valid[2];
      end
      chk("abort_no_out", 128'(seen), 128'(0));
      load_key(2, K256, 1'b0);
      issue(2, 1'b0, PT, CT256, 1'b1, w);
      wait_out(2, "enc_after_rst");
      release_out(2, 0, CT256);

      for (int g = 0; g < 2; g++) begin
         load_key(g, (g == 0) ? K128 : K192, 1'b0);
         issue(g, 1'b0, PT, (g == 0) ? CT128 : CT192, 1'b1, w);
         wait_out(g, $sformatf("enc%0d", 128 + 64 * g));
         release_out(g, g + 1, (g == 0) ? CT128 : CT192);
         issue(g, 1'b1, (g == 0) ? CT128 : CT192, PT, 1'b1, w);
         wait_out(g, $sformatf("dec%0d", 128 + 64 * g));
         release_out(g, 0, PT);
      end

      repeat (3) @(negedge clk);
      chk("sb_empty", 128'(sb.size()), 128'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
